// File: rtl/puf_soc_pkg.sv
// Shared types and constants for the PUF SoC control sequencer.
package puf_soc_pkg;

    // State code width; matches the datapath i_fsm_state input.
    localparam int ST_W = 3;

    // State codes as seen by the datapath. Code 7 is unused and treated as illegal.
    typedef enum logic [ST_W-1:0] {
        S_IDLE = 3'd0,
        S_RECV = 3'd1,
        S_DCOD = 3'd2,
        S_EXEC = 3'd3,
        S_TRAN = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_e;

    // Host operating modes.
    localparam logic NORM  = 1'b0;
    localparam logic DEBUG = 1'b1;

endpackage

// File: rtl/puf_soc_wdog.sv
// Execute/transmit watchdog: a saturating cycle counter with a synchronous
// clear. expire flags the last allowed cycle (count == TIMEOUT_CYC-1).
module puf_soc_wdog #(
    parameter int TIMEOUT_CYC = 1024,
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [CNT_W-1:0] count;

    // Count enabled cycles; saturate at TIMEOUT_CYC so the counter never wraps.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en && (count != CNT_W'(TIMEOUT_CYC))) begin
            count <= count + 1'b1;
        end
    end

    assign expire = (count >= CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/puf_soc_ctrl_fsm.sv
// Control sequencer for the PUF SoC datapath: one challenge transaction
// (receive, decode, execute, transmit) per accepted start request, with a
// watchdog on execute/transmit, a host abort and an error state.
module puf_soc_ctrl_fsm
    import puf_soc_pkg::*;
#(
    parameter int MUX_LENGTH  = 16,
    parameter int TIMEOUT_CYC = 1024,
    localparam int SEL_W = $clog2(MUX_LENGTH)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_start,
    input  logic               i_op_mode,
    input  logic               i_abort,
    input  logic               i_err_clr,
    input  logic               i_dp_rx_ready,
    input  logic               i_dp_rx_valid,
    input  logic [2*SEL_W-1:0] i_dp_rx_data,
    input  logic               i_dp_exec_done,
    input  logic               i_dp_tx_done,
    output logic               o_op_mode,
    output logic               o_rx_ready,
    output logic               o_dcod_en,
    output logic               o_cnt_en,
    output logic               o_tx_en,
    output logic [ST_W-1:0]    o_fsm_state,
    output logic [SEL_W-1:0]   o_sel_mux_0,
    output logic [SEL_W-1:0]   o_sel_mux_1,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_timeout
);

    localparam logic [ST_W-1:0] ST_IDLE = S_IDLE;
    localparam logic [ST_W-1:0] ST_RECV = S_RECV;
    localparam logic [ST_W-1:0] ST_DCOD = S_DCOD;
    localparam logic [ST_W-1:0] ST_EXEC = S_EXEC;
    localparam logic [ST_W-1:0] ST_TRAN = S_TRAN;
    localparam logic [ST_W-1:0] ST_DONE = S_DONE;
    localparam logic [ST_W-1:0] ST_ERR  = S_ERR;

    logic [ST_W-1:0]  state;
    logic [ST_W-1:0]  state_nxt;
    logic             op_mode;
    logic [SEL_W-1:0] sel0;
    logic [SEL_W-1:0] sel1;
    logic             wd_clr;
    logic             wd_en;
    logic             wd_expire;

    // Receiver ready is a status-only input: the transition out of RECV
    // waits on rx_valid alone, so this is intentionally left unconsumed.
    logic rx_ready_unused;
    assign rx_ready_unused = i_dp_rx_ready;

    // Next-state logic. Abort beats done/valid events, which beat the
    // watchdog, so a done arriving on the expiry cycle still advances.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (i_start) state_nxt = ST_RECV;
            ST_RECV: begin
                if (i_abort)            state_nxt = ST_IDLE;
                else if (i_dp_rx_valid) state_nxt = ST_DCOD;
            end
            ST_DCOD: state_nxt = i_abort ? ST_IDLE : ST_EXEC;
            ST_EXEC: begin
                if (i_abort)             state_nxt = ST_IDLE;
                else if (i_dp_exec_done) state_nxt = ST_TRAN;
                else if (wd_expire)      state_nxt = ST_ERR;
            end
            ST_TRAN: begin
                if (i_abort)           state_nxt = ST_IDLE;
                else if (i_dp_tx_done) state_nxt = ST_DONE;
                else if (wd_expire)    state_nxt = ST_ERR;
            end
            ST_DONE: state_nxt = ST_IDLE;
            ST_ERR:  if (i_err_clr) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State, latched mode and challenge selects. Selects persist across
    // DONE/abort and only change on an accepted challenge byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            op_mode <= NORM;
            sel0    <= '0;
            sel1    <= '0;
        end else begin
            state <= state_nxt;
            if ((state == ST_IDLE) && i_start) begin
                op_mode <= i_op_mode;
            end
            if ((state == ST_RECV) && !i_abort && i_dp_rx_valid) begin
                {sel1, sel0} <= i_dp_rx_data;
            end
        end
    end

    // Watchdog restarts on every state change, so entering EXEC or TRAN
    // always begins from zero.
    assign wd_clr = (state_nxt != state);
    assign wd_en  = (state == ST_EXEC) || (state == ST_TRAN);

    puf_soc_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (wd_expire)
    );

    // Outputs are a pure decode of registered state.
    assign o_fsm_state = state;
    assign o_rx_ready  = (state == ST_RECV);
    assign o_dcod_en   = (state == ST_DCOD);
    assign o_cnt_en    = (state == ST_EXEC);
    assign o_tx_en     = (state == ST_TRAN);
    assign o_done      = (state == ST_DONE);
    assign o_timeout   = (state == ST_ERR);
    assign o_busy      = (state != ST_IDLE);
    assign o_op_mode   = op_mode;
    assign o_sel_mux_0 = sel0;
    assign o_sel_mux_1 = sel1;

endmodule

// File: tb/tb_puf_soc_ctrl_fsm.sv
// Self-checking bench for puf_soc_ctrl_fsm. Each transaction is described by
// its wait times; the expected per-cycle state timeline is built from those
// numbers and the sequencing rules, then replayed against the DUT.
module tb_puf_soc_ctrl_fsm;

    localparam int MUX_LENGTH = 16;
    localparam int SEL_W      = 4;
    localparam int TMO        = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst;
    logic               i_start, i_op_mode, i_abort, i_err_clr;
    logic               i_dp_rx_ready, i_dp_rx_valid, i_dp_exec_done, i_dp_tx_done;
    logic [2*SEL_W-1:0] i_dp_rx_data;
    logic               o_op_mode, o_rx_ready, o_dcod_en, o_cnt_en, o_tx_en;
    logic [2:0]         o_fsm_state;
    logic [SEL_W-1:0]   o_sel_mux_0, o_sel_mux_1;
    logic               o_busy, o_done, o_timeout;

    puf_soc_ctrl_fsm #(
        .MUX_LENGTH  (MUX_LENGTH),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_start        (i_start),
        .i_op_mode      (i_op_mode),
        .i_abort        (i_abort),
        .i_err_clr      (i_err_clr),
        .i_dp_rx_ready  (i_dp_rx_ready),
        .i_dp_rx_valid  (i_dp_rx_valid),
        .i_dp_rx_data   (i_dp_rx_data),
        .i_dp_exec_done (i_dp_exec_done),
        .i_dp_tx_done   (i_dp_tx_done),
        .o_op_mode      (o_op_mode),
        .o_rx_ready     (o_rx_ready),
        .o_dcod_en      (o_dcod_en),
        .o_cnt_en       (o_cnt_en),
        .o_tx_en        (o_tx_en),
        .o_fsm_state    (o_fsm_state),
        .o_sel_mux_0    (o_sel_mux_0),
        .o_sel_mux_1    (o_sel_mux_1),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_timeout      (o_timeout)
    );

    // One expected cycle: state code plus the events the bench drives in it.
    typedef struct packed {
        logic [2:0] st;
        logic       v;    // rx_valid
        logic       xd;   // exec_done
        logic       td;   // tx_done
        logic       ab;   // abort
        logic       rs;   // reset
    } cyc_t;

    cyc_t       q[$];
    int         n_checks = 0;
    int         n_errs   = 0;
    logic [7:0] exp_sel;
    logic       exp_mode;

    function automatic cyc_t mk(input logic [2:0] st, input logic v, input logic xd, input logic td);
        cyc_t c;
        c = '0;
        c.st = st; c.v = v; c.xd = xd; c.td = td;
        return c;
    endfunction

    // Expected {rx_ready, dcod_en, cnt_en, tx_en, busy, done, timeout} per state.
    function automatic logic [6:0] exp_dec(input logic [2:0] st);
        case (st)
            3'd1:    return 7'b1000100;
            3'd2:    return 7'b0100100;
            3'd3:    return 7'b0010100;
            3'd4:    return 7'b0001100;
            3'd5:    return 7'b0000110;
            3'd6:    return 7'b0000101;
            default: return 7'b0000000;
        endcase
    endfunction

    // Runs one transaction from an IDLE cycle (called at its negedge).
    // rxd/xd/td: idle cycles before rx_valid/exec_done/tx_done; a wait of
    // TMO or more means the done never comes. brk: timeline index at which
    // abort (or reset if brk_rst) is applied, ignored unless in RECV..TRAN.
    task automatic run_txn(input string tag, input int rxd, input int xd, input int td,
                           input logic mode, input logic [7:0] data,
                           input int brk, input bit brk_rst, input bit hold);
        int   n;
        bit   err;
        logic [6:0] obs;
        err = 0;
        q.delete();
        for (int i = 0; i <= rxd; i++) q.push_back(mk(3'd1, i == rxd, 1'b0, 1'b0));
        q.push_back(mk(3'd2, 1'b0, 1'b0, 1'b0));
        n = (xd < TMO) ? xd + 1 : TMO;
        for (int i = 0; i < n; i++) q.push_back(mk(3'd3, 1'b0, (xd < TMO) && (i == xd), 1'b0));
        if (xd >= TMO) err = 1;
        if (!err) begin
            n = (td < TMO) ? td + 1 : TMO;
            for (int i = 0; i < n; i++) q.push_back(mk(3'd4, 1'b0, 1'b0, (td < TMO) && (i == td)));
            if (td >= TMO) err = 1;
            else q.push_back(mk(3'd5, 1'b0, 1'b0, 1'b0));
        end
        q.push_back(mk(err ? 3'd6 : 3'd0, 1'b0, 1'b0, 1'b0));
        if (brk >= 0 && brk < q.size() && q[brk].st >= 3'd1 && q[brk].st <= 3'd4) begin
            q[brk].ab = !brk_rst;
            q[brk].rs = brk_rst;
            while (q.size() > brk + 1) void'(q.pop_back());
            q.push_back(mk(3'd0, 1'b0, 1'b0, 1'b0));
        end

        i_start = 1'b1; i_op_mode = mode;
        @(posedge clk); #1;
        i_start = hold;
        exp_mode = mode;
        foreach (q[k]) begin
            if (k > 0) begin @(posedge clk); #1; end
            i_dp_rx_valid  = q[k].v;
            i_abort        = q[k].ab;
            rst            = q[k].rs;
            i_dp_rx_data   = q[k].v ? data : 8'($urandom);
            i_dp_rx_ready  = 1'($urandom);
            // Stray done strobes where they must be ignored.
            i_dp_exec_done = (q[k].st == 3'd3) ? q[k].xd :
                             (q[k].st == 3'd1 || q[k].st == 3'd2 || q[k].st == 3'd4) ? 1'($urandom) : 1'b0;
            i_dp_tx_done   = (q[k].st == 3'd4) ? q[k].td :
                             (q[k].st == 3'd1 || q[k].st == 3'd2 || q[k].st == 3'd3) ? 1'($urandom) : 1'b0;
            @(negedge clk);
            obs = {o_rx_ready, o_dcod_en, o_cnt_en, o_tx_en, o_busy, o_done, o_timeout};
            n_checks++;
            if (o_fsm_state !== q[k].st) begin
                n_errs++;
                $display("FAIL %s state cyc %0d: got %0d, want %0d", tag, k, o_fsm_state, q[k].st);
            end
            n_checks++;
            if (obs !== exp_dec(q[k].st)) begin
                n_errs++;
                $display("FAIL %s outputs cyc %0d: got %b, want %b", tag, k, obs, exp_dec(q[k].st));
            end
            n_checks++;
            if ({o_sel_mux_1, o_sel_mux_0, o_op_mode} !== {exp_sel, exp_mode}) begin
                n_errs++;
                $display("FAIL %s sel/mode cyc %0d: got %h/%b, want %h/%b", tag, k,
                         {o_sel_mux_1, o_sel_mux_0}, o_op_mode, exp_sel, exp_mode);
            end
            if (q[k].rs) begin
                exp_sel = 8'h00; exp_mode = 1'b0;
            end else if (q[k].v && !q[k].ab) begin
                exp_sel = data;
            end
        end
        i_dp_rx_valid = 0; i_dp_exec_done = 0; i_dp_tx_done = 0; i_abort = 0; rst = 0;

        // ERR holds against start and abort; only err_clr leaves it.
        if (q[q.size()-1].st == 3'd6) begin
            for (int i = 0; i < 2; i++) begin
                @(posedge clk); #1;
                i_start = 1'b1; i_abort = (i == 1);
                @(negedge clk);
                n_checks++;
                if (o_fsm_state !== 3'd6 || o_timeout !== 1'b1 || o_cnt_en !== 1'b0 || o_tx_en !== 1'b0) begin
                    n_errs++;
                    $display("FAIL %s err_hold %0d: state %0d timeout %b cnt_en %b tx_en %b, want 6 1 0 0",
                             tag, i, o_fsm_state, o_timeout, o_cnt_en, o_tx_en);
                end
            end
            i_abort = 1'b0; i_err_clr = 1'b1;
            @(posedge clk); #1;
            i_err_clr = 1'b0; i_start = hold;
            @(negedge clk);
            n_checks++;
            if (o_fsm_state !== 3'd0 || o_timeout !== 1'b0 || o_busy !== 1'b0) begin
                n_errs++;
                $display("FAIL %s err_clr: state %0d timeout %b busy %b, want 0 0 0",
                         tag, o_fsm_state, o_timeout, o_busy);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 2) rst = 1'b0;
            @(negedge clk);
            n_checks++;
            if ({o_fsm_state, o_rx_ready, o_dcod_en, o_cnt_en, o_tx_en, o_busy, o_done, o_timeout,
                 o_op_mode, o_sel_mux_1, o_sel_mux_0} !== 19'd0) begin
                n_errs++;
                $display("FAIL reset cyc %0d: state %0d busy %b sel %h mode %b, want all zero",
                         i, o_fsm_state, o_busy, {o_sel_mux_1, o_sel_mux_0}, o_op_mode);
            end
        end
        exp_sel = 8'h00; exp_mode = 1'b0;
    endtask

    task automatic test_basic();
        // tx wait kept under the 16-cycle watchdog this bench is built with.
        run_txn("basic", 2, 10, 12, 1'b1, 8'hA5, -1, 0, 0);
        n_checks++;
        if (o_sel_mux_0 !== 4'h5 || o_sel_mux_1 !== 4'hA || o_op_mode !== 1'b1) begin
            n_errs++;
            $display("FAIL basic_latch: sel0 %h sel1 %h mode %b, want 5 a 1", o_sel_mux_0, o_sel_mux_1, o_op_mode);
        end
    endtask

    task automatic test_min_txn();
        run_txn("min_txn", 0, 0, 0, 1'b0, 8'h42, -1, 0, 0);
    endtask

    task automatic test_exec_timeout();
        run_txn("exec_tmo", 1, TMO + 5, 0, 1'b0, 8'h69, -1, 0, 0);
    endtask

    task automatic test_tran_timeout();
        run_txn("tran_tmo", 0, 2, TMO, 1'b1, 8'h18, -1, 0, 0);
    endtask

    task automatic test_coincident();
        run_txn("coinc", 0, TMO - 1, TMO - 1, 1'b0, 8'hC3, -1, 0, 0);
    endtask

    task automatic test_abort();
        // Index 10 falls in TRAN: RECV 0-1, DCOD 2, EXEC 3-6, TRAN 7-15.
        run_txn("abort_tran", 1, 3, 8, 1'b0, 8'h7E, 10, 0, 0);
        n_checks++;
        if (o_sel_mux_0 !== 4'hE || o_sel_mux_1 !== 4'h7) begin
            n_errs++;
            $display("FAIL abort_tran_sel: sel0 %h sel1 %h, want e 7", o_sel_mux_0, o_sel_mux_1);
        end
        // Abort on the rx_valid cycle: no challenge is latched.
        run_txn("abort_recv", 2, 0, 0, 1'b1, 8'h11, 2, 0, 0);
        n_checks++;
        if (o_sel_mux_0 !== 4'hE || o_sel_mux_1 !== 4'h7) begin
            n_errs++;
            $display("FAIL abort_recv_sel: sel0 %h sel1 %h, want e 7", o_sel_mux_0, o_sel_mux_1);
        end
    endtask

    task automatic test_reset_mid_exec();
        run_txn("rst_exec", 0, 8, 0, 1'b1, 8'hD2, 5, 1, 0);
        n_checks++;
        if (o_sel_mux_0 !== 4'h0 || o_sel_mux_1 !== 4'h0 || o_op_mode !== 1'b0 || o_busy !== 1'b0) begin
            n_errs++;
            $display("FAIL rst_exec_clear: sel %h mode %b busy %b, want 00 0 0",
                     {o_sel_mux_1, o_sel_mux_0}, o_op_mode, o_busy);
        end
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_1", 0, 0, 0, 1'b1, 8'h96, -1, 0, 1);
        run_txn("b2b_2", 1, 2, 3, 1'b0, 8'h3C, -1, 0, 1);
        i_start = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (o_fsm_state !== 3'd0 || o_sel_mux_0 !== 4'hC || o_sel_mux_1 !== 4'h3 || o_op_mode !== 1'b0) begin
            n_errs++;
            $display("FAIL b2b_final: state %0d sel0 %h sel1 %h mode %b, want 0 c 3 0",
                     o_fsm_state, o_sel_mux_0, o_sel_mux_1, o_op_mode);
        end
    endtask

    task automatic test_random();
        int brk;
        for (int t = 0; t < 30; t++) begin
            brk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 25)) : -1;
            run_txn($sformatf("rand%0d", t), $urandom_range(0, 3), $urandom_range(0, TMO + 1),
                    $urandom_range(0, TMO + 1), 1'($urandom), 8'($urandom), brk,
                    1'($urandom), 1'($urandom));
        end
        i_start = 1'b0;
    endtask

    initial begin
        rst = 1'b1; i_start = 0; i_op_mode = 0; i_abort = 0; i_err_clr = 0;
        i_dp_rx_ready = 0; i_dp_rx_valid = 0; i_dp_rx_data = '0;
        i_dp_exec_done = 0; i_dp_tx_done = 0;
        exp_sel = 8'h00; exp_mode = 1'b0;
        test_reset();
        test_basic();
        test_min_txn();
        test_exec_timeout();
        test_tran_timeout();
        test_coincident();
        test_abort();
        test_reset_mid_exec();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: summary not reached within time limit");
        $fatal(1, "time limit");
    end

endmodule
